apb_master_arbiter: RTL

- Shares one APB master port between NB_REQ requesters, e.g. a core data port, a debug module and a DMA, all driving the slave side of the peripheral APB node.
- Round-robin arbitration at transfer granularity. Drives a standard SETUP/ACCESS sequence downstream.
- A per-transfer timeout returns an error if a peripheral never responds.

---
 rtl/apb_master_arbiter_if.sv | 40 ++++
 rtl/apb_master_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter_if.sv
// Bundle of the requester-side and downstream APB signals of the arbiter.
// "master" is the arbiter's own view; "slave" is the view of the requesters and peripheral.
interface apb_master_arbiter_if #(
    parameter int unsigned NB_REQ         = 3,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
);
    logic [NB_REQ-1:0]                req_psel_i;
    logic [NB_REQ-1:0]                req_penable_i;
    logic [NB_REQ*APB_ADDR_WIDTH-1:0] req_paddr_i;
    logic [NB_REQ-1:0]                req_pwrite_i;
    logic [NB_REQ*APB_DATA_WIDTH-1:0] req_pwdata_i;
    logic [APB_DATA_WIDTH-1:0]        req_prdata_o;
    logic [NB_REQ-1:0]                req_pready_o;
    logic [NB_REQ-1:0]                req_pslverr_o;
    logic                             psel_o;
    logic                             penable_o;
    logic [APB_ADDR_WIDTH-1:0]        paddr_o;
    logic                             pwrite_o;
    logic [APB_DATA_WIDTH-1:0]        pwdata_o;
    logic [APB_DATA_WIDTH-1:0]        prdata_i;
    logic                             pready_i;
    logic                             pslverr_i;
    logic [NB_REQ-1:0]                grant_o;
    logic                             busy_o;

    modport master (
        input  req_psel_i, req_penable_i, req_paddr_i, req_pwrite_i, req_pwdata_i,
               prdata_i, pready_i, pslverr_i,
        output req_prdata_o, req_pready_o, req_pslverr_o,
               psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, grant_o, busy_o
    );

    modport slave (
        output req_psel_i, req_penable_i, req_paddr_i, req_pwrite_i, req_pwdata_i,
               prdata_i, pready_i, pslverr_i,
        input  req_prdata_o, req_pready_o, req_pslverr_o,
               psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, grant_o, busy_o
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NB_REQ requesters,
// with a per-transfer ACCESS timeout that forces an error completion.
module apb_master_arbiter #(
    parameter int unsigned NB_REQ         = 3,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    apb_master_arbiter_if.master bus
);
    localparam int unsigned AW    = APB_ADDR_WIDTH;
    localparam int unsigned DW    = APB_DATA_WIDTH;
    localparam int unsigned IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e              state;
    state_e              state_next;
    logic [NB_REQ-1:0]   grant;
    logic [IDX_W-1:0]    last_grant;
    logic [AW-1:0]       paddr;
    logic                pwrite;
    logic [DW-1:0]       pwdata;
    logic [15:0]         count;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic [NB_REQ-1:0]   pick_onehot;
    logic [AW-1:0]       pick_addr;
    logic                pick_write;
    logic [DW-1:0]       pick_data;
    int unsigned         k;

    logic                complete_ok;
    logic                complete_to;
    logic                unused_penable;

    // penable from the requesters carries no information for arbitration
    assign unused_penable = ^bus.req_penable_i;

    assign complete_ok = (state == ACCESS) && bus.pready_i;
    assign complete_to = (state == ACCESS) && !bus.pready_i &&
                         (TIMEOUT_CYCLES != 16'd0) && (count == TIMEOUT_CYCLES - 16'd1);

    // first requester set at or after last_grant+1, wrapping
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_addr  = '0;
        pick_write = 1'b0;
        pick_data  = '0;
        k          = 0;
        for (int unsigned i = 1; i <= NB_REQ; i++) begin
            k = (32'(last_grant) + i) % NB_REQ;
            if (!pick_valid && bus.req_psel_i[k]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(k);
                pick_addr  = bus.req_paddr_i[k*AW +: AW];
                pick_write = bus.req_pwrite_i[k];
                pick_data  = bus.req_pwdata_i[k*DW +: DW];
            end
        end
        pick_onehot = NB_REQ'(1) << pick_idx;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (complete_ok || complete_to) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // completion signals are combinational so the requester sees pready in the same cycle
    always_comb begin
        bus.psel_o        = (state != IDLE);
        bus.penable_o     = (state == ACCESS);
        bus.busy_o        = (state != IDLE);
        bus.grant_o       = (state != IDLE) ? grant : '0;
        bus.paddr_o       = paddr;
        bus.pwrite_o      = pwrite;
        bus.pwdata_o      = pwdata;
        bus.req_pready_o  = '0;
        bus.req_pslverr_o = '0;
        bus.req_prdata_o  = '0;
        if (complete_ok) begin
            bus.req_pready_o  = grant;
            bus.req_pslverr_o = bus.pslverr_i ? grant : '0;
            bus.req_prdata_o  = bus.prdata_i;
        end else if (complete_to) begin
            bus.req_pready_o  = grant;
            bus.req_pslverr_o = grant;
        end
    end

    // owner, round-robin pointer, latched transfer and ACCESS cycle counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant      <= '0;
            last_grant <= IDX_W'(NB_REQ - 1);
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            count      <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                grant      <= pick_onehot;
                last_grant <= pick_idx;
                paddr      <= pick_addr;
                pwrite     <= pick_write;
                pwdata     <= pick_data;
            end
            if (complete_ok || complete_to) begin
                grant <= '0;
                count <= '0;
            end else if (state == ACCESS) begin
                count <= count + 16'd1;
            end
        end
    end
endmodule
